// File: rtl/fec_parity_gearbox.sv
// (2112,2080) FC KR FEC parity generator and 65b->66b gearbox: 32 blocks in, 32 words out per frame.
// Latency 1 cycle per accepted block; no backpressure, parity word 31 is deferred to the next block 0 slot.
module fec_parity_gearbox #(
    parameter logic [31:0] POLY = 32'h00A00805,
    parameter int          NBLK = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        T_BLK_ENA,
    input  logic [64:0] T_BLK,
    input  logic [4:0]  BLK_CNT,
    output logic [65:0] FEC_BLK,
    output logic        FEC_BLK_ENA,
    output logic [4:0]  FEC_WORD_CNT,
    output logic        ALIGN_ERR
);

    localparam logic [4:0] LAST_IDX = 5'(NBLK - 1);
    localparam logic [6:0] BLK_BITS = 7'd65;

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t         state;
    logic [129:0]   buf_q;
    logic [6:0]     res_q;
    logic [31:0]    lfsr_q;
    logic [4:0]     exp_q;

    logic [129:0]   blk_top;
    logic [129:0]   app;
    logic [31:0]    lfsr_upd;
    logic [31:0]    lfsr_first;
    logic [4:0]     exp_nxt;
    logic           idx_ok;

    // MSB-first division by g(x), unrolled over one 65-bit block.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [64:0] d);
        logic [31:0] r;
        logic        fb;
        r = s;
        for (int i = 64; i >= 0; i--) begin
            fb = d[i] ^ r[31];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    // Buffer is left-justified: the oldest residue bit sits at buf_q[129], bits below the residue are zero.
    assign blk_top    = {T_BLK, 65'b0};
    assign app        = buf_q | (blk_top >> res_q);
    assign lfsr_upd   = lfsr_step(lfsr_q, T_BLK);
    assign lfsr_first = lfsr_step(32'h0, T_BLK);
    assign idx_ok     = (BLK_CNT == exp_q);
    assign exp_nxt    = (BLK_CNT == LAST_IDX) ? 5'd0 : BLK_CNT + 5'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= HUNT;
            buf_q        <= '0;
            res_q        <= '0;
            lfsr_q       <= '0;
            exp_q        <= '0;
            FEC_BLK      <= '0;
            FEC_BLK_ENA  <= 1'b0;
            FEC_WORD_CNT <= '0;
            ALIGN_ERR    <= 1'b0;
        end else begin
            FEC_BLK_ENA <= 1'b0;
            ALIGN_ERR   <= 1'b0;
            if (T_BLK_ENA) begin
                case (state)
                    HUNT: begin
                        if (BLK_CNT == 5'd0) begin
                            buf_q  <= blk_top;
                            res_q  <= BLK_BITS;
                            lfsr_q <= lfsr_first;
                            exp_q  <= 5'd1;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (!idx_ok) begin
                            ALIGN_ERR <= 1'b1;
                            buf_q     <= '0;
                            res_q     <= '0;
                            lfsr_q    <= '0;
                            exp_q     <= '0;
                            state     <= HUNT;
                        end else if (BLK_CNT == 5'd0) begin
                            // Deferred word 31: 34 residue data bits followed by the finished parity.
                            FEC_BLK      <= {buf_q[129:96], lfsr_q};
                            FEC_BLK_ENA  <= 1'b1;
                            FEC_WORD_CNT <= LAST_IDX;
                            buf_q        <= blk_top;
                            res_q        <= BLK_BITS;
                            lfsr_q       <= lfsr_first;
                            exp_q        <= 5'd1;
                        end else begin
                            FEC_BLK      <= app[129:64];
                            FEC_BLK_ENA  <= 1'b1;
                            FEC_WORD_CNT <= BLK_CNT - 5'd1;
                            buf_q        <= {app[63:0], 66'b0};
                            res_q        <= res_q - 7'd1;
                            lfsr_q       <= lfsr_upd;
                            exp_q        <= exp_nxt;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fec_parity_gearbox.sv
// Self-checking bench for fec_parity_gearbox against a frame-level bit-array model with long-division parity.
module tb_fec_parity_gearbox;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        T_BLK_ENA = 1'b0;
    logic [64:0] T_BLK = '0;
    logic [4:0]  BLK_CNT = '0;
    logic [65:0] FEC_BLK;
    logic        FEC_BLK_ENA;
    logic [4:0]  FEC_WORD_CNT;
    logic        ALIGN_ERR;

    int checks = 0;
    int errors = 0;

    fec_parity_gearbox dut (
        .CLK(CLK), .RST(RST), .T_BLK_ENA(T_BLK_ENA), .T_BLK(T_BLK), .BLK_CNT(BLK_CNT),
        .FEC_BLK(FEC_BLK), .FEC_BLK_ENA(FEC_BLK_ENA), .FEC_WORD_CNT(FEC_WORD_CNT), .ALIGN_ERR(ALIGN_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: whole frame as a bit array, d0 at index 0, parity at 2080..2111.
    bit          m_run;
    int          m_exp;
    bit          fbits [0:2111];
    logic [65:0] m_pend;
    logic        e_ena, e_err;
    logic [4:0]  e_cnt;
    logic [65:0] e_blk;

    function automatic bit g_has(input int deg);
        return (deg == 32 || deg == 23 || deg == 21 || deg == 11 || deg == 2 || deg == 0);
    endfunction

    function automatic logic [31:0] ref_parity();
        bit          r [0:2111];
        logic [31:0] p;
        for (int i = 0; i < 2112; i++) r[i] = (i < 2080) ? fbits[i] : 1'b0;
        for (int i = 0; i < 2080; i++)
            if (r[i])
                for (int k = 0; k <= 32; k++)
                    if (g_has(32 - k)) r[i + k] = ~r[i + k];
        for (int i = 0; i < 32; i++) p[31 - i] = r[2080 + i];
        return p;
    endfunction

    function automatic logic [65:0] frame_word(input int k);
        logic [65:0] w;
        for (int b = 0; b < 66; b++) w[65 - b] = fbits[66 * k + b];
        return w;
    endfunction

    function automatic void store_blk(input int j, input logic [64:0] blk);
        for (int b = 0; b < 65; b++) fbits[65 * j + b] = blk[64 - b];
    endfunction

    function automatic void model(input bit rst, input bit ena, input logic [4:0] cnt, input logic [64:0] blk);
        logic [31:0] p;
        e_ena = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_exp = 0; e_blk = '0; e_cnt = '0;
        end else if (ena) begin
            if (!m_run) begin
                if (cnt == 5'd0) begin
                    store_blk(0, blk); m_run = 1'b1; m_exp = 1;
                end
            end else if (int'(cnt) != m_exp) begin
                e_err = 1'b1; m_run = 1'b0; m_exp = 0;
            end else begin
                store_blk(int'(cnt), blk);
                e_ena = 1'b1;
                if (cnt == 5'd0) begin
                    e_blk = m_pend; e_cnt = 5'd31;
                end else begin
                    e_blk = frame_word(int'(cnt) - 1); e_cnt = cnt - 5'd1;
                end
                if (cnt == 5'd31) begin
                    p = ref_parity();
                    for (int i = 0; i < 32; i++) fbits[2080 + i] = p[31 - i];
                    m_pend = frame_word(31);
                end
                m_exp = (m_exp + 1) % 32;
            end
        end
    endfunction

    task automatic step(input bit rst, input bit ena, input logic [4:0] cnt, input logic [64:0] blk);
        RST = rst; T_BLK_ENA = ena; BLK_CNT = cnt; T_BLK = blk;
        model(rst, ena, cnt, blk);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [72:0] obs_v();
        return {FEC_BLK_ENA, ALIGN_ERR, FEC_WORD_CNT, FEC_BLK};
    endfunction

    function automatic logic [72:0] exp_v();
        return {e_ena, e_err, e_cnt, e_blk};
    endfunction

    function automatic logic [64:0] rnd65();
        return {1'(($urandom)), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b1, 5'd0, rnd65());
        step(1'b1, 1'b0, 5'd0, '0);
        checks++;
        if (obs_v() !== 73'b0) begin
            errors++; $display("FAIL reset_state got %h expected 0", obs_v());
        end
    endtask

    task automatic test_zero_frame();
        int nwords = 0;
        step(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 33; i++) begin
            step(1'b0, 1'b1, 5'(i % 32), '0);
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++; $display("FAIL zero_frame blk%0d got %h expected %h", i, obs_v(), exp_v());
            end
            if (FEC_BLK_ENA === 1'b1) begin
                checks++;
                if (FEC_WORD_CNT !== 5'(nwords) || FEC_BLK !== 66'h0) begin
                    errors++; $display("FAIL zero_word_seq got cnt %0d data %h expected cnt %0d data 0", FEC_WORD_CNT, FEC_BLK, nwords);
                end
                nwords++;
            end
        end
        checks++;
        if (nwords != 32) begin
            errors++; $display("FAIL zero_word_count got %0d expected 32", nwords);
        end
    endtask

    task automatic test_parity_single();
        step(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 33; i++) begin
            step(1'b0, 1'b1, 5'(i % 32), (i == 31) ? 65'h1 : 65'h0);
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++; $display("FAIL parity_frame blk%0d got %h expected %h", i, obs_v(), exp_v());
            end
        end
        checks++;
        if ({FEC_BLK_ENA, FEC_WORD_CNT, FEC_BLK} !== {1'b1, 5'd31, 66'h1_00A0_0805}) begin
            errors++; $display("FAIL parity_word31 got ena %b cnt %0d data %h expected 1 31 0100a00805", FEC_BLK_ENA, FEC_WORD_CNT, FEC_BLK);
        end
    endtask

    task automatic test_word0();
        step(1'b1, 1'b0, 5'd0, '0);
        step(1'b0, 1'b1, 5'd0, 65'h1_FFFF_FFFF_FFFF_FFFF);
        checks++;
        if (FEC_BLK_ENA !== 1'b0) begin
            errors++; $display("FAIL word0_first_blk0 got ena %b expected 0", FEC_BLK_ENA);
        end
        step(1'b0, 1'b1, 5'd1, 65'h0);
        checks++;
        if ({FEC_BLK_ENA, FEC_WORD_CNT, FEC_BLK} !== {1'b1, 5'd0, 66'h3_FFFF_FFFF_FFFF_FFFE}) begin
            errors++; $display("FAIL word0_value got ena %b cnt %0d data %h expected 1 0 3fffffffffffffffe", FEC_BLK_ENA, FEC_WORD_CNT, FEC_BLK);
        end
    endtask

    task automatic test_random_gaps();
        int gap;
        step(1'b1, 1'b0, 5'd0, '0);
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 32; j++) begin
                gap = (f == 1 && j == 0) ? 50 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 5'($urandom), rnd65());
                    checks++;
                    if (obs_v() !== exp_v()) begin
                        errors++; $display("FAIL random_idle f%0d b%0d got %h expected %h", f, j, obs_v(), exp_v());
                    end
                end
                step(1'b0, 1'b1, 5'(j), rnd65());
                checks++;
                if (obs_v() !== exp_v()) begin
                    errors++; $display("FAIL random_blk f%0d b%0d got %h expected %h", f, j, obs_v(), exp_v());
                end
            end
        end
        step(1'b0, 1'b1, 5'd0, rnd65());
        checks++;
        if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL random_flush got %h expected %h", obs_v(), exp_v());
        end
    endtask

    task automatic test_align();
        int seq [18] = '{0, 1, 2, 3, 4, 5, 7, -1, 6, 3, 0, 1, 2, 3, 0, 1, 0, 1};
        step(1'b1, 1'b0, 5'd0, '0);
        foreach (seq[i]) begin
            step(1'b0, seq[i] >= 0, 5'(seq[i] < 0 ? 0 : seq[i]), rnd65());
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++; $display("FAIL align_seq step%0d got %h expected %h", i, obs_v(), exp_v());
            end
            if (i == 6 || i == 14) begin
                checks++;
                if ({ALIGN_ERR, FEC_BLK_ENA} !== 2'b10) begin
                    errors++; $display("FAIL align_pulse step%0d got err %b ena %b expected err 1 ena 0", i, ALIGN_ERR, FEC_BLK_ENA);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        step(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 5'(i), rnd65());
        step(1'b1, 1'b1, 5'd17, rnd65());
        checks++;
        if (obs_v() !== 73'b0) begin
            errors++; $display("FAIL rst_mid_outputs got %h expected 0", obs_v());
        end
        for (int i = 0; i < 33; i++) begin
            step(1'b0, 1'b1, 5'(i % 32), rnd65());
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++; $display("FAIL rst_mid_frame blk%0d got %h expected %h", i, obs_v(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_parity_single();
        test_word0();
        test_random_gaps();
        test_align();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
